// File: rtl/div_iter_unit_if.sv
// Handshake bundle between the EX-stage hazard unit (master) and the
// iterative divider (slave).
interface div_iter_unit_if #(
  parameter int DATA_W = 32
);
  logic                  div_start;
  logic                  div_signed;
  logic [DATA_W-1:0]     div_opdata1;
  logic [DATA_W-1:0]     div_opdata2;
  logic                  div_annul;
  logic                  div_ready;
  logic                  div_busy;
  logic [2*DATA_W-1:0]   div_result;

  modport master (
    output div_start, div_signed, div_opdata1, div_opdata2, div_annul,
    input  div_ready, div_busy, div_result
  );

  modport slave (
    input  div_start, div_signed, div_opdata1, div_opdata2, div_annul,
    output div_ready, div_busy, div_result
  );
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle; signed operands are
// divided as magnitudes and sign-corrected when the result is written.
module div_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  div_iter_unit_if.slave    bus
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ZERO = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic                  load_s;
  logic                  step_s;
  logic                  fin_s;
  logic                  zero_fin_s;
  logic [2*DATA_W-1:0]   pr_r;
  logic [2*DATA_W-1:0]   pr_nx_s;
  logic [DATA_W-1:0]     dvs_r;
  logic [DATA_W-1:0]     dvd_r;
  logic                  neg_q_r;
  logic                  neg_rem_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  ready_r;
  logic                  busy_r;
  logic [2*DATA_W-1:0]   result_r;
  logic [DATA_W-1:0]     abs_a_s;
  logic [DATA_W-1:0]     abs_b_s;
  logic [DATA_W:0]       rem_sh_s;
  logic [DATA_W:0]       diff_s;
  logic [DATA_W-1:0]     quo_fix_s;
  logic [DATA_W-1:0]     rem_fix_s;

  assign abs_a_s = (bus.div_signed && bus.div_opdata1[DATA_W-1]) ?
                   ({DATA_W{1'b0}} - bus.div_opdata1) : bus.div_opdata1;
  assign abs_b_s = (bus.div_signed && bus.div_opdata2[DATA_W-1]) ?
                   ({DATA_W{1'b0}} - bus.div_opdata2) : bus.div_opdata2;

  // Upper half shifted left by one; a clear borrow bit means the subtract fits.
  assign rem_sh_s  = pr_r[2*DATA_W-1:DATA_W-1];
  assign diff_s    = rem_sh_s - {1'b0, dvs_r};
  assign pr_nx_s   = diff_s[DATA_W] ? {pr_r[2*DATA_W-2:0], 1'b0}
                                    : {diff_s[DATA_W-1:0], pr_r[DATA_W-2:0], 1'b1};
  assign quo_fix_s = neg_q_r   ? ({DATA_W{1'b0}} - pr_nx_s[DATA_W-1:0]) : pr_nx_s[DATA_W-1:0];
  assign rem_fix_s = neg_rem_r ? ({DATA_W{1'b0}} - pr_nx_s[2*DATA_W-1:DATA_W])
                               : pr_nx_s[2*DATA_W-1:DATA_W];

  assign bus.div_ready  = ready_r;
  assign bus.div_busy   = busy_r;
  assign bus.div_result = result_r;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and datapath control; a dropped start counts as an abort.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    fin_s      = 1'b0;
    zero_fin_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.div_start && !bus.div_annul) begin
          load_s = 1'b1;
          if (bus.div_opdata2 == {DATA_W{1'b0}}) begin
            state_nx_s = ST_ZERO;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!bus.div_start || bus.div_annul) begin
          state_nx_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == CNT_W'(DATA_W-1)) begin
            fin_s      = 1'b1;
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_BUSY;
          end
        end
      end
      ST_ZERO: begin
        if (!bus.div_start || bus.div_annul) begin
          state_nx_s = ST_IDLE;
        end else begin
          zero_fin_s = 1'b1;
          state_nx_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_r      <= {(2*DATA_W){1'b0}};
      dvs_r     <= {DATA_W{1'b0}};
      dvd_r     <= {DATA_W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      result_r  <= {(2*DATA_W){1'b0}};
    end else begin
      ready_r <= fin_s | zero_fin_s;
      busy_r  <= (state_nx_s == ST_BUSY) || (state_nx_s == ST_ZERO);
      if (load_s) begin
        pr_r      <= {{DATA_W{1'b0}}, abs_a_s};
        dvs_r     <= abs_b_s;
        dvd_r     <= bus.div_opdata1;
        neg_q_r   <= bus.div_signed & (bus.div_opdata1[DATA_W-1] ^ bus.div_opdata2[DATA_W-1]);
        neg_rem_r <= bus.div_signed & bus.div_opdata1[DATA_W-1];
        cnt_r     <= {CNT_W{1'b0}};
      end else if (step_s) begin
        pr_r  <= pr_nx_s;
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (fin_s) begin
        result_r <= {rem_fix_s, quo_fix_s};
      end else if (zero_fin_s) begin
        result_r <= {dvd_r, {DATA_W{1'b1}}};
      end
    end
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// Directed bench for div_iter_unit: a driver emulating the hazard unit pushes
// expected {HI,LO} and completion cycle; a negedge monitor pops and compares.
module tb_div_iter_unit;
  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       nm;
  } exp_t;

  exp_t sb_q[$];

  div_iter_unit_if #(.DATA_W(32)) bus ();

  div_iter_unit #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.div_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        chk({e.nm, "_result"}, bus.div_result, e.res);
        chk({e.nm, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  // Hazard-unit emulation: start held until ready, then one idle cycle.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [63:0] exp, input int lat, input string nm);
    bit got;
    sb_q.push_back('{exp, cyc + lat, nm});
    bus.div_start   = 1'b1;
    bus.div_signed  = sg;
    bus.div_opdata1 = a;
    bus.div_opdata2 = b;
    @(posedge clk); #1;
    bus.div_opdata1 = ~a;
    bus.div_opdata2 = ~b;
    bus.div_signed  = ~sg;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (bus.div_ready === 1'b1) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no ready expected ready within 60 cycles", nm);
    end
    bus.div_start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.div_start   = 1'b0;
    bus.div_signed  = 1'b0;
    bus.div_opdata1 = 32'h0;
    bus.div_opdata2 = 32'h0;
    bus.div_annul   = 1'b0;
    #22;
    rst = 1'b0;
    #1;
    chk("reset_ready",  64'(bus.div_ready), 64'h0);
    chk("reset_busy",   64'(bus.div_busy),  64'h0);
    chk("reset_result", bus.div_result,     64'h0);
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, "u_100_7");
    repeat (5) @(posedge clk);
    #1;
    chk("u_100_7_held", bus.div_result, 64'h00000002_0000000E);

    run_div(32'hFFFFFFF9, 32'd2,        1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, "s_m7_2");
    run_div(32'd7,        32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, "s_7_m2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, "s_min_m1");
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 64'hFFFFFFFE_0000000E, 33, "s_m100_m7");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 33, "u_min_max");
    run_div(32'h12345678, 32'h0,        1'b0, 64'h12345678_FFFFFFFF, 2,  "u_div0");
    run_div(32'hFFFFFFF9, 32'h0,        1'b1, 64'hFFFFFFF9_FFFFFFFF, 2,  "s_div0");

    // Abort by annul part-way through: no pulse, result untouched.
    bus.div_start   = 1'b1;
    bus.div_signed  = 1'b0;
    bus.div_opdata1 = 32'd100;
    bus.div_opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_before", 64'(bus.div_busy), 64'h1);
    bus.div_annul = 1'b1;
    @(posedge clk); #1;
    bus.div_annul = 1'b0;
    bus.div_start = 1'b0;
    chk("abort_busy_after", 64'(bus.div_busy), 64'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("abort_result_held", bus.div_result, 64'hFFFFFFF9_FFFFFFFF);
    run_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, "u_9_3");

    // Back-to-back pair through the handshake emulation.
    run_div(32'd50,       32'd5,  1'b0, 64'h00000000_0000000A, 33, "u_50_5");
    run_div(32'hFFFFFFFF, 32'd16, 1'b0, 64'h0000000F_0FFFFFFF, 33, "u_max_16");

    // Asynchronous reset between edges while busy.
    bus.div_start   = 1'b1;
    bus.div_signed  = 1'b0;
    bus.div_opdata1 = 32'd100;
    bus.div_opdata2 = 32'd7;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_ready",  64'(bus.div_ready), 64'h0);
    chk("arst_busy",   64'(bus.div_busy),  64'h0);
    chk("arst_result", bus.div_result,     64'h0);
    bus.div_start = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run_div(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 33, "u_after_rst");

    repeat (5) @(posedge clk);
    #1;
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s_missing: got no ready expected result %h", e.nm, e.res);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
